mmio_responder: RTL and testbench

Memory-mapped I/O responder at the far end of the core's data-memory port. It accepts load/store requests from the MEM stage through a valid/ready handshake and returns read data or an error through a held response. It owns the 11-bit `io_output_bus` register, synchronizes `io_input_bus`, latches sticky input-change flags and runs a cycle timer.

---
 rtl/mmio_responder_pkg.sv | 19 +
 rtl/mmio_responder_synchronizer.sv | 26 ++
 rtl/mmio_responder.sv | 101 ++++++++++
 tb/tb_mmio_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg: shared widths, MMIO register offsets and FSM state encodings
// Contents:
//   DEF_XLEN / DEF_IO_WIDTH / DEF_ADDR_WIDTH : default widths for the responder
//   MMIO_OUT / MMIO_IN / MMIO_CHANGE / MMIO_TIMER : byte offsets inside the window
//   ST_IDLE / ST_ACCESS / ST_RESPOND : FSM state encodings
package mmio_responder_pkg;
    localparam int DEF_XLEN       = 32;
    localparam int DEF_IO_WIDTH   = 11;
    localparam int DEF_ADDR_WIDTH = 4;

    localparam logic [3:0] MMIO_OUT    = 4'h0;
    localparam logic [3:0] MMIO_IN     = 4'h4;
    localparam logic [3:0] MMIO_CHANGE = 4'h8;
    localparam logic [3:0] MMIO_TIMER  = 4'hC;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;
endpackage

// File: rtl/mmio_responder_synchronizer.sv
// mmio_responder_synchronizer: two-flop synchronizer for asynchronous inputs
// Ports:
//   clock : sampling clock
//   reset : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output, two clock edges behind d
module mmio_responder_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO load/store responder with output register, synchronized inputs, change flags and timer
// Ports:
//   clock, reset                        : clock and asynchronous active-low reset
//   req_valid/req_ready/req_write       : request handshake and direction (1 = store)
//   req_address/req_write_data          : byte offset and store data
//   resp_valid/resp_ready               : held response handshake
//   resp_read_data/resp_error           : load data (0 for stores/errors), error flag
//   io_input_bus/io_output_bus          : asynchronous inputs, registered outputs
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int IO_WIDTH   = DEF_IO_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [XLEN-1:0]       req_write_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_read_data,
    output logic                  resp_error,
    input  logic [IO_WIDTH-1:0]   io_input_bus,
    output logic [IO_WIDTH-1:0]   io_output_bus
);
    logic [1:0]            state;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       data_q;
    logic [IO_WIDTH-1:0]   sync_in;
    logic [IO_WIDTH-1:0]   prev_in;
    logic [IO_WIDTH-1:0]   change;
    logic [IO_WIDTH-1:0]   clr;
    logic [XLEN-1:0]       timer;
    logic [XLEN-1:0]       rd_data;
    logic [3:0]            off;
    logic                  ok;
    logic                  access;
    logic                  wr_en;

    mmio_responder_synchronizer #(.WIDTH(IO_WIDTH)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (io_input_bus),
        .q     (sync_in)
    );

    // Gated with reset so the initiator sees not-ready while reset is held.
    assign req_ready  = reset && state == ST_IDLE;
    assign resp_valid = state == ST_RESPOND;
    assign access     = state == ST_ACCESS;
    assign off        = addr_q[3:0];
    // Anything past the four mapped words only exists for wider address widths.
    assign ok         = addr_q[1:0] == 2'b00 && 32'(addr_q) < 32'd16;
    assign wr_en      = access && wr_q && ok;
    assign clr        = (wr_en && off == MMIO_CHANGE) ? data_q[IO_WIDTH-1:0] : '0;

    always_comb begin
        rd_data = off == MMIO_OUT    ? XLEN'(io_output_bus) :
                  off == MMIO_IN     ? XLEN'(sync_in) :
                  off == MMIO_CHANGE ? XLEN'(change) : timer;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            resp_read_data <= '0;
            resp_error     <= 1'b0;
            io_output_bus  <= '0;
            prev_in        <= '0;
            change         <= '0;
            timer          <= '0;
        end else begin
            prev_in <= sync_in;
            // New edges are OR-ed in after the clear so a same-cycle set survives.
            change  <= (change & ~clr) | (sync_in ^ prev_in);
            timer   <= (wr_en && off == MMIO_TIMER) ? data_q : timer + XLEN'(1);
            if (wr_en && off == MMIO_OUT)
                io_output_bus <= data_q[IO_WIDTH-1:0];
            if (req_ready && req_valid) begin
                wr_q   <= req_write;
                addr_q <= req_address;
                data_q <= req_write_data;
            end
            if (access) begin
                resp_error     <= !ok;
                resp_read_data <= (ok && !wr_q) ? rd_data : '0;
            end
            state <= state == ST_IDLE   ? (req_valid ? ST_ACCESS : ST_IDLE) :
                     state == ST_ACCESS ? ST_RESPOND :
                     (resp_ready ? ST_IDLE : ST_RESPOND);
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: scoreboard bench for mmio_responder with randomized traffic and a history-based model
module tb_mmio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_address = 4'h0;
    logic [31:0] req_write_data = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic [10:0] io_input_bus = 11'h0;
    logic [10:0] io_output_bus;

    mmio_responder dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_read_data (resp_read_data),
        .resp_error     (resp_error),
        .io_input_bus   (io_input_bus),
        .io_output_bus  (io_output_bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    bit          have = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference state: edges since reset release, input value seen at each edge,
    // change-flag value after each edge, pending clear, output and timer anchors.
    int          cyc = 0;
    logic [10:0] hist [0:4095];
    logic [10:0] chg_hist [0:4095];
    logic [10:0] chg_m = 11'h0;
    int          clr_at = -1;
    logic [10:0] clr_mask = 11'h0;
    logic [10:0] out_m = 11'h0;
    int          tw_edge = 0;
    logic [31:0] tw_val = 32'h0;

    function automatic logic [10:0] h(input int i);
        return (i < 1) ? 11'h0 : hist[i];
    endfunction

    // A flag rises at edge k when the input seen two edges earlier differs from the one before it.
    function automatic logic [10:0] chg_next(input int k);
        return (chg_m & ~((clr_at == k) ? clr_mask : 11'h0)) | (h(k - 2) ^ h(k - 3));
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc   <= 0;
            chg_m <= 11'h0;
        end else if (cyc < 4094) begin
            hist[cyc + 1]     <= io_input_bus;
            chg_hist[cyc + 1] <= chg_next(cyc + 1);
            chg_m             <= chg_next(cyc + 1);
            cyc               <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (resp_valid) begin
            if (!have) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got response %h with empty scoreboard", resp_read_data);
                end else begin
                    cur  = q.pop_front();
                    have = 1;
                end
            end
            if (have) begin
                chk("resp_read_data", resp_read_data, cur.data);
                chk("resp_error", 32'(resp_error), 32'(cur.err));
            end
        end else begin
            have = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d, input int hold);
        int   n;
        int   r;
        exp_t x;
        logic ok;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_address = a;
        req_write_data = d;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("accept", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_address = 4'($urandom);
        req_write_data = $urandom;
        r = cyc + 1;
        ok = a[1:0] == 2'b00;
        x.err = !ok;
        x.data = 32'h0;
        if (ok && !w) begin
            if (a[3:2] == 2'd0) x.data = {21'h0, out_m};
            if (a[3:2] == 2'd1) x.data = {21'h0, h(r - 2)};
            if (a[3:2] == 2'd2) x.data = {21'h0, chg_hist[r - 1]};
            if (a[3:2] == 2'd3) x.data = tw_val + 32'(r - 1 - tw_edge);
        end
        if (ok && w) begin
            if (a[3:2] == 2'd0) out_m = d[10:0];
            if (a[3:2] == 2'd2) begin
                clr_at = r;
                clr_mask = d[10:0];
            end
            if (a[3:2] == 2'd3) begin
                tw_edge = r;
                tw_val = d;
            end
        end
        q.push_back(x);
        chk("resp_valid_early", 32'(resp_valid), 32'd0);
        resp_ready = (hold == 0);
        @(negedge clock);
        chk("resp_valid_latency", 32'(resp_valid), 32'd1);
        chk("io_output_bus", 32'(io_output_bus), 32'(out_m));
    endtask

    task automatic finish_resp(input int hold);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_address = 4'h0;
            req_write_data = $urandom;
            @(negedge clock);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        chk("resp_released", 32'(resp_valid), 32'd0);
        chk("io_output_held", 32'(io_output_bus), 32'(out_m));
    endtask

    task automatic xact(input logic w, input logic [3:0] a, input logic [31:0] d, input int hold);
        issue(w, a, d, hold);
        finish_resp(hold);
    endtask

    initial begin
        logic [3:0] a;
        int         hold;
        #1 reset = 1'b0;
        io_input_bus = 11'h7FF;
        idle(3);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_read_data", resp_read_data, 32'h0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_io_output_bus", 32'(io_output_bus), 32'h0);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_release", 32'(req_ready), 32'd1);
        idle(2);
        xact(1'b0, 4'h8, 32'h0, 0);
        xact(1'b1, 4'h0, 32'h0000_05A5, 0);
        xact(1'b0, 4'h0, 32'h0, 0);
        xact(1'b0, 4'h4, 32'h0, 0);
        xact(1'b1, 4'h8, 32'h0000_07FF, 0);
        io_input_bus ^= 11'h008;
        idle(3);
        xact(1'b0, 4'h8, 32'h0, 0);
        io_input_bus ^= 11'h008;
        @(negedge clock);
        xact(1'b1, 4'h8, 32'h0000_0008, 0);
        xact(1'b0, 4'h8, 32'h0, 0);
        xact(1'b1, 4'hC, 32'hFFFF_FFFE, 0);
        idle(3);
        xact(1'b0, 4'hC, 32'h0, 0);
        xact(1'b0, 4'h6, 32'h0, 0);
        xact(1'b1, 4'h5, 32'h0000_0123, 0);
        xact(1'b1, 4'h4, 32'h0000_0321, 0);
        xact(1'b0, 4'h0, 32'h0, 0);
        xact(1'b0, 4'hC, 32'h0, 5);
        repeat (60) begin
            if ($urandom_range(2) == 0) io_input_bus ^= 11'($urandom);
            idle($urandom_range(2));
            a = ($urandom_range(4) == 0) ? 4'($urandom) : {2'($urandom), 2'b00};
            hold = ($urandom_range(3) == 0) ? $urandom_range(3) : 0;
            xact(1'($urandom), a, $urandom, hold);
        end
        issue(1'b0, 4'hC, 32'h0, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_read_data", resp_read_data, 32'h0);
        chk("midrst_io_output_bus", 32'(io_output_bus), 32'h0);
        q.delete();
        out_m = 11'h0;
        tw_edge = 0;
        tw_val = 32'h0;
        clr_at = -1;
        resp_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        xact(1'b0, 4'h0, 32'h0, 0);
        xact(1'b0, 4'hC, 32'h0, 0);
        xact(1'b0, 4'h8, 32'h0, 0);
        idle(2);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end
endmodule
